// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_pkg : VGA state encodings and default 640x480@60 timing         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package vga_pkg;

  localparam int c_hres   = 640;
  localparam int c_h_fp   = 16;
  localparam int c_h_sync = 96;
  localparam int c_h_bp   = 48;
  localparam int c_vres   = 480;
  localparam int c_v_fp   = 10;
  localparam int c_v_sync = 2;
  localparam int c_v_bp   = 33;
  localparam int c_htotal = c_hres + c_h_fp + c_h_sync + c_h_bp;
  localparam int c_vtotal = c_vres + c_v_fp + c_v_sync + c_v_bp;

  // Generic axis phase encoding shared by both counters
  localparam logic [1:0] c_st_active = 2'd0;
  localparam logic [1:0] c_st_front  = 2'd1;
  localparam logic [1:0] c_st_sync   = 2'd2;
  localparam logic [1:0] c_st_back   = 2'd3;

  typedef enum logic [1:0] {
    H_ACTIVE = 2'd0,
    H_FRONT  = 2'd1,
    H_SYNC   = 2'd2,
    H_BACK   = 2'd3
  } h_state_t;

  typedef enum logic [1:0] {
    V_ACTIVE = 2'd0,
    V_FRONT  = 2'd1,
    V_SYNC   = 2'd2,
    V_BACK   = 2'd3
  } v_state_t;

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_axis_counter : wrapping position counter with porch/sync FSM    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FRONT  = 16,
  parameter int SYNC   = 96,
  parameter int BACK   = 48
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  output logic [9:0] count,
  output logic [1:0] state_next,
  output logic       wrap
);

  localparam int         TOTAL      = ACTIVE + FRONT + SYNC + BACK;
  localparam logic [9:0] c_last     = 10'(TOTAL - 1);
  localparam logic [9:0] c_front_at = 10'(ACTIVE);
  localparam logic [9:0] c_sync_at  = 10'(ACTIVE + FRONT);
  localparam logic [9:0] c_back_at  = 10'(ACTIVE + FRONT + SYNC);

  logic [9:0] r_count;
  logic [1:0] r_state;
  logic [9:0] w_count_next;
  logic [1:0] w_state_next;
  logic       w_wrap;

  // Next-state values are exported so the parent can register decodes
  // in the same edge as the counter, keeping them aligned with count.
  always_comb begin
    w_wrap       = tick && (r_count == c_last);
    w_count_next = r_count;
    w_state_next = r_state;
    if (tick) begin
      w_count_next = w_wrap ? 10'd0 : r_count + 10'd1;
      if (w_count_next == 10'd0)
        w_state_next = c_st_active;
      else if (w_count_next == c_front_at)
        w_state_next = c_st_front;
      else if (w_count_next == c_sync_at)
        w_state_next = c_st_sync;
      else if (w_count_next == c_back_at)
        w_state_next = c_st_back;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 10'd0;
      r_state <= c_st_active;
    end else begin
      r_count <= w_count_next;
      r_state <= w_state_next;
    end
  end

  assign count      = r_count;
  assign state_next = w_state_next;
  assign wrap       = w_wrap;

endmodule
`default_nettype wire

// File: rtl/vga_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_controller : VGA raster timing generator with registered decodes |
// | Option macro VGA_PIXEL_DIV2_EN: pixel rate = clk/2                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module vga_controller #(
  parameter int HRES   = vga_pkg::c_hres,
  parameter int VRES   = vga_pkg::c_vres,
  parameter int H_FP   = vga_pkg::c_h_fp,
  parameter int H_SYNC = vga_pkg::c_h_sync,
  parameter int H_BP   = vga_pkg::c_h_bp,
  parameter int V_FP   = vga_pkg::c_v_fp,
  parameter int V_SYNC = vga_pkg::c_v_sync,
  parameter int V_BP   = vga_pkg::c_v_bp
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       vga_clk,
  output logic       hsync,
  output logic       vsync,
  output logic       blank_n,
  output logic       sync_n,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_start
);

  import vga_pkg::*;

  logic       w_pix_en;
  logic       r_run;
  logic       w_h_tick;
  logic       w_line_end;
  logic       w_frame_end;
  logic [1:0] w_h_sn;
  logic [1:0] w_v_sn;
  h_state_t   w_h_state;
  v_state_t   w_v_state;

`ifdef VGA_PIXEL_DIV2_EN
  logic r_div;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_div <= 1'b0;
    else        r_div <= ~r_div;
  end

  assign w_pix_en = r_div;
  assign vga_clk  = r_div;
`else
  assign w_pix_en = 1'b1;
  assign vga_clk  = clk;
`endif

  // The first tick after reset presents position 0,0 rather than advancing.
  assign w_h_tick = w_pix_en & r_run;

  vga_axis_counter #(
    .ACTIVE (HRES),
    .FRONT  (H_FP),
    .SYNC   (H_SYNC),
    .BACK   (H_BP)
  ) u_h_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (w_h_tick),
    .count      (x),
    .state_next (w_h_sn),
    .wrap       (w_line_end)
  );

  vga_axis_counter #(
    .ACTIVE (VRES),
    .FRONT  (V_FP),
    .SYNC   (V_SYNC),
    .BACK   (V_BP)
  ) u_v_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (w_line_end),
    .count      (y),
    .state_next (w_v_sn),
    .wrap       (w_frame_end)
  );

  assign w_h_state = h_state_t'(w_h_sn);
  assign w_v_state = v_state_t'(w_v_sn);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run       <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      blank_n     <= 1'b0;
      frame_start <= 1'b0;
    end else if (w_pix_en) begin
      r_run       <= 1'b1;
      hsync       <= (w_h_state != vga_pkg::H_SYNC);
      vsync       <= (w_v_state != vga_pkg::V_SYNC);
      blank_n     <= (w_h_state == vga_pkg::H_ACTIVE) &&
                     (w_v_state == vga_pkg::V_ACTIVE);
      frame_start <= ~r_run | w_frame_end;
    end
  end

  assign sync_n = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_vga_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vga_controller : self-checking bench, default and reduced raster  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_vga_controller;

`ifdef VGA_PIXEL_DIV2_EN
  localparam int DIV = 2;
`else
  localparam int DIV = 1;
`endif

  // Reduced geometry so whole frames fit in a short run
  localparam int S_HR = 8, S_HFP = 2, S_HS = 3, S_HBP = 2;
  localparam int S_VR = 6, S_VFP = 1, S_VS = 2, S_VBP = 2;

  typedef struct {
    int x; int y; int hs; int vs; int bn; int fs;
  } exp_t;

  typedef struct {
    int t; int x; int y; int hs; int vs; int bn; int fs;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       d_vga_clk, d_hsync, d_vsync, d_blank_n, d_sync_n, d_fs;
  logic [9:0] d_x, d_y;
  logic       s_vga_clk, s_hsync, s_vsync, s_blank_n, s_sync_n, s_fs;
  logic [9:0] s_x, s_y;

  int n_tests = 0;
  int n_fail  = 0;
  int t       = 0;

  always #5 clk = ~clk;

  vga_controller dut_d (
    .clk(clk), .rst_n(rst_n), .vga_clk(d_vga_clk), .hsync(d_hsync),
    .vsync(d_vsync), .blank_n(d_blank_n), .sync_n(d_sync_n),
    .x(d_x), .y(d_y), .frame_start(d_fs)
  );

  vga_controller #(
    .HRES(S_HR), .VRES(S_VR), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .vga_clk(s_vga_clk), .hsync(s_hsync),
    .vsync(s_vsync), .blank_n(s_blank_n), .sync_n(s_sync_n),
    .x(s_x), .y(s_y), .frame_start(s_fs)
  );

  // Raster position and decodes for pixel tick number tt since frame start
  function automatic exp_t model(int tt, int hr, int hfp, int hsw, int hbp,
                                 int vr, int vfp, int vsw, int vbp);
    exp_t m;
    int ht = hr + hfp + hsw + hbp;
    int vt = vr + vfp + vsw + vbp;
    m.x  = tt % ht;
    m.y  = (tt / ht) % vt;
    m.hs = (m.x >= hr + hfp && m.x < hr + hfp + hsw) ? 0 : 1;
    m.vs = (m.y >= vr + vfp && m.y < vr + vfp + vsw) ? 0 : 1;
    m.bn = (m.x < hr && m.y < vr) ? 1 : 0;
    m.fs = (m.x == 0 && m.y == 0) ? 1 : 0;
    return m;
  endfunction

  task automatic cmp(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (tick %0d)", name, act, exp, t);
    end
  endtask

  task automatic cmp_d(string tag, exp_t e);
    cmp({tag, ".d.x"},  int'(d_x), e.x);
    cmp({tag, ".d.y"},  int'(d_y), e.y);
    cmp({tag, ".d.hs"}, int'(d_hsync), e.hs);
    cmp({tag, ".d.vs"}, int'(d_vsync), e.vs);
    cmp({tag, ".d.bn"}, int'(d_blank_n), e.bn);
    cmp({tag, ".d.fs"}, int'(d_fs), e.fs);
  endtask

  task automatic cmp_s(string tag, exp_t e);
    cmp({tag, ".s.x"},  int'(s_x), e.x);
    cmp({tag, ".s.y"},  int'(s_y), e.y);
    cmp({tag, ".s.hs"}, int'(s_hsync), e.hs);
    cmp({tag, ".s.vs"}, int'(s_vsync), e.vs);
    cmp({tag, ".s.bn"}, int'(s_blank_n), e.bn);
    cmp({tag, ".s.fs"}, int'(s_fs), e.fs);
  endtask

  task automatic check_model(string tag);
    cmp_d(tag, model(t, 640, 16, 96, 48, 480, 10, 2, 33));
    cmp_s(tag, model(t, S_HR, S_HFP, S_HS, S_HBP, S_VR, S_VFP, S_VS, S_VBP));
  endtask

  task automatic adv(int n);
    repeat (n * DIV) @(negedge clk);
    t += n;
  endtask

  // Release at a negedge, then wait (bounded) for the first pixel tick
  task automatic release_rst();
    int k = 0;
    rst_n = 1'b1;
    do begin
      @(negedge clk);
      k++;
    end while (!d_blank_n && k < 8);
    cmp("first_tick_seen", int'(d_blank_n), 1);
    t = 0;
  endtask

  task automatic check_reset(string tag);
    exp_t r;
    r = '{x: 0, y: 0, hs: 1, vs: 1, bn: 0, fs: 0};
    cmp_d(tag, r);
    cmp_s(tag, r);
  endtask

  vec_t tbl[10];

  initial begin
    int hs_low, hs_first, bn_fall, s_vs_low, s_fs_cnt, x_chg, vc_chg;
    logic [9:0] px;
    logic pv;
    exp_t e;

    // Default-geometry checkpoints along lines 0..2
    tbl[0] = '{1,    1,   0, 1, 1, 1, 0};
    tbl[1] = '{639,  639, 0, 1, 1, 1, 0};
    tbl[2] = '{640,  640, 0, 1, 1, 0, 0};
    tbl[3] = '{655,  655, 0, 1, 1, 0, 0};
    tbl[4] = '{656,  656, 0, 0, 1, 0, 0};
    tbl[5] = '{751,  751, 0, 0, 1, 0, 0};
    tbl[6] = '{752,  752, 0, 1, 1, 0, 0};
    tbl[7] = '{799,  799, 0, 1, 1, 0, 0};
    tbl[8] = '{800,  0,   1, 1, 1, 1, 0};
    tbl[9] = '{1601, 1,   2, 1, 1, 1, 0};

    repeat (3) @(negedge clk);
    check_reset("reset");
    cmp("sync_n", int'(d_sync_n), 0);

    release_rst();
    check_model("first");

    for (int i = 0; i < 10; i++) begin
      adv(tbl[i].t - t);
      e = '{x: tbl[i].x, y: tbl[i].y, hs: tbl[i].hs, vs: tbl[i].vs,
            bn: tbl[i].bn, fs: tbl[i].fs};
      cmp_d($sformatf("tbl%0d", i), e);
    end

    // Fresh start, then scan ticks 0..839 tick by tick
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    release_rst();
    hs_low = 0; hs_first = -1; bn_fall = -1; s_vs_low = 0; s_fs_cnt = 0;
    for (int i = 0; i < 840; i++) begin
      check_model("scan");
      if (i < 800) begin
        if (!d_hsync) begin
          hs_low++;
          if (hs_first < 0) hs_first = int'(d_x);
        end
        if (!d_blank_n && bn_fall < 0) bn_fall = int'(d_x);
      end
      if (i < 165 && !s_vsync) s_vs_low++;
      if (s_fs) s_fs_cnt++;
      adv(1);
    end
    cmp("hsync_low_ticks", hs_low, 96);
    cmp("hsync_first_x", hs_first, 656);
    cmp("blank_fall_x", bn_fall, 640);
    cmp("s_vsync_low_ticks", s_vs_low, 2 * 15);
    cmp("s_frame_start_count", s_fs_cnt, 6);

    // Pixel rate and pixel clock relative to clk
    x_chg = 0; vc_chg = 0;
    px = d_x; pv = d_vga_clk;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (d_x != px) x_chg++;
      if (d_vga_clk != pv) vc_chg++;
      px = d_x; pv = d_vga_clk;
    end
    t += 8 / DIV;
    cmp("x_advances", x_chg, 8 / DIV);
    if (DIV == 1) begin
      cmp("vga_clk_low_at_negedge", int'(d_vga_clk), 0);
      @(posedge clk); #1;
      cmp("vga_clk_high_at_posedge", int'(d_vga_clk), 1);
      @(negedge clk);
      t += 1;
    end else begin
      cmp("vga_clk_toggles", vc_chg, 8);
    end
    check_model("after_rate");

    // Asynchronous reset at x=300, y=2
    adv(1900 - t);
    cmp("pre_reset_x", int'(d_x), 300);
    #2 rst_n = 1'b0;
    #1 check_reset("async_reset");
    @(negedge clk);
    @(negedge clk);
    release_rst();
    check_model("post_reset");

    // Random advances with occasional resets, checked against the model
    for (int i = 0; i < 30; i++) begin
      adv($urandom_range(1, 300));
      check_model("rand");
      if ($urandom_range(0, 7) == 0) begin
        rst_n = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        release_rst();
        check_model("rand_reset");
      end
    end

    // Frame wrap on the reduced raster: last pixel then 0,0
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    release_rst();
    adv(164);
    cmp_s("frame_last", '{x: 14, y: 10, hs: 1, vs: 1, bn: 0, fs: 0});
    adv(1);
    cmp_s("frame_wrap", '{x: 0, y: 0, hs: 1, vs: 1, bn: 1, fs: 1});
    adv(1);
    cmp("frame_start_drop", int'(s_fs), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
